wb_commit_buffer: RTL and testbench
===================================

// Module: wb_commit_buffer
// PURPOSE
// - RV32I writeback stage directly upstream of the register file. Accepts retired MEM-stage results over valid/ready.
// - Formats load data and selects the writeback source, then queues results in a small FIFO.
// - Drains one entry per cycle into the register-file write port (reg_write/rd_addr/rd_data), gated by the same start enable.
// - Also reports pending-write hazards to decode for rs1/rs2.
// PARAMETERS
// - XLEN   32  datapath width
// - DEPTH  2   FIFO entries; power of two, >=2
// - AW     $clog2(DEPTH)  pointer width (derived; do not override)
// PORTS
// - clk           in   1     clock; all state updates on posedge
// - reset         in   1     asynchronous, active-high; clears all state
// - start         in   1     global enable; drain allowed only when 1
// - in_valid      in   1     upstream result valid
// - in_ready      out  1     buffer can accept this cycle
// - in_reg_write  in   1     result targets a register
// - in_rd_addr    in   5     destination register
// - in_wb_sel     in   2     00 ALU, 01 MEM load, 10 PC+4, 11 IMM (LUI)
// - in_funct3     in   3     load type (used when wb_sel=01)
// - in_alu_result in   XLEN  ALU result / load address ([1:0] = byte offset)
// - in_mem_rdata  in   XLEN  raw aligned word from data memory
// - in_pc_plus4   in   XLEN  PC+4 (JAL/JALR link)
// - in_imm        in   XLEN  U-type immediate
// - rf_reg_write  out  1     register-file write enable
// - rf_rd_addr    out  5     register-file write address
// - rf_rd_data    out  XLEN  register-file write data
// - rs1_query     in   5     decode source address 1
// - rs2_query     in   5     decode source address 2
// - hazard_rs1    out  1     pending write to rs1_query
// - hazard_rs2    out  1     pending write to rs2_query
// - occupancy     out  AW+1  entries currently buffered
// BEHAVIOUR
// - Reset values: rf_reg_write=0, rf_rd_addr=0, rf_rd_data=0, occupancy=0, pointers=0, all entries invalid.
//   Reset mid-operation discards every queued entry.
// - in_ready = (occupancy != DEPTH).
//   Depends only on registered state, never on start or on a same-cycle pop; when full, in_ready=0 even if a pop occurs.
// - Push: in_valid && in_ready at posedge stores {we, rd, data}.
//   we = in_reg_write && (in_rd_addr != 0). Entries with we=0 still occupy a slot and drain in order.
// - data is computed combinationally at push:
//   - 00 -> alu_result; 10 -> pc_plus4; 11 -> imm.
//   - 01 -> load formatting with off = alu_result[1:0]:
//     - LB 000: sext(byte[off]); LBU 100: zext(byte[off])
//     - LH 001: sext(half[off[1]]); LHU 101: zext(half[off[1]])
//     - LW 010 and any other funct3: full word unchanged
//   - Misalignment is not checked here; it is trapped upstream.
// - Pop: at posedge with start=1 and occupancy!=0, head moves to rf_* regs (rf_reg_write <= head.we) and the read pointer advances.
//   - Otherwise rf_reg_write <= 0; rf_rd_addr and rf_rd_data hold their values.
//   - start=0 freezes the drain; pushes continue until full.
// - Latency: push at edge N -> rf_* valid after edge N+1 (if start) -> register file commits at edge N+2.
//   Throughput: 1 result/cycle in steady state.
// - Simultaneous push and pop (not full): occupancy unchanged; entry order strictly FIFO.
//   Pointers wrap modulo DEPTH.
// - hazard_rsX = (rsX_query != 0) && (any valid entry with we=1 and rd==rsX_query, OR rf_reg_write=1 and rf_rd_addr==rsX_query).
//   Combinational over registered state only; query 0 never hazards.
// STRUCTURE
// - Shared package rv32_wb_pkg:
//   - WB_SEL_ALU/MEM/PC4/IMM (2-bit)
//   - F3_LB/LH/LW/LBU/LHU (3-bit)
//   - entry width constant 1+5+XLEN
// - Sub-module wb_load_align: combinational (funct3, off, rdata) -> formatted XLEN word.
// - Top holds the source mux, FIFO array, pointers/occupancy, rf output regs and hazard compare.
// TESTING
// - Reset/idle: assert reset with 1 entry queued -> occupancy=0, rf_reg_write=0, in_ready=1, hazard_rs1=0 next cycle.
// - Load format: sel=01, rdata=0x8899AABB:
//   - off=1, LB  -> rf_rd_data=0xFFFFFFAA
//   - off=1, LBU -> 0x000000AA
//   - off=2, LH  -> 0xFFFF8899
//   - off=2, LHU -> 0x00008899
//   - LW         -> 0x8899AABB
// - Source mux and x0: sel=10 pc_plus4=0x104 rd=5 -> rf write x5=0x104 two edges after push; rd=0 -> rf_reg_write stays 0, slot still consumed.
// - Stall/full: start=0, push 3 results (DEPTH=2) -> third held with in_ready=0, occupancy=2.
//   Raise start -> writes emerge in push order on consecutive cycles.
// - Streaming wrap: start=1, 8 back-to-back pushes -> 8 consecutive rf writes, each 1 edge after its push, no drops or duplicates.
// - Hazard: queue write to x7 -> hazard_rs1=1 for rs1_query=7, 0 for query 8 and query 0; clears the cycle after rf_reg_write for x7 drops.

Source files
------------

// File: rtl/rv32_wb_pkg.sv
// Shared writeback-stage encodings: result source select, load funct3 codes
// and the packed width of one queued commit entry.
package rv32_wb_pkg;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;
  localparam logic [1:0] WB_SEL_IMM = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int RD_W = 5;

  // Entry layout, MSB first: {we, rd, data}.
  function automatic int entry_width(input int xlen);
    return 1 + RD_W + xlen;
  endfunction

  localparam int ENTRY_W = entry_width(32);

endpackage

// File: rtl/wb_load_align.sv
// Load result formatting: picks the addressed byte/half of an aligned memory
// word and sign- or zero-extends it according to funct3.
module wb_load_align
  import rv32_wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    // Unknown funct3 codes fall through to the full word.
    data = rdata;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_commit_buffer.sv
// RV32I writeback commit buffer: formats retired results, queues them in a
// small FIFO and drains one per cycle into the register-file write port.
module wb_commit_buffer
  import rv32_wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_reg_write,
  input  logic [4:0]      in_rd_addr,
  input  logic [1:0]      in_wb_sel,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_mem_rdata,
  input  logic [XLEN-1:0] in_pc_plus4,
  input  logic [XLEN-1:0] in_imm,
  output logic            rf_reg_write,
  output logic [4:0]      rf_rd_addr,
  output logic [XLEN-1:0] rf_rd_data,
  input  logic [4:0]      rs1_query,
  input  logic [4:0]      rs2_query,
  output logic            hazard_rs1,
  output logic            hazard_rs2,
  output logic [AW:0]     occupancy
);

  localparam int          EW     = entry_width(XLEN);
  localparam int          WE_BIT = EW - 1;
  localparam int          RD_MSB = EW - 2;
  localparam logic [AW:0] FULL   = DEPTH[AW:0];

  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] push_data;
  logic            push_we;
  logic            push;
  logic            pop;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [EW-1:0]   entries [DEPTH];
  logic [EW-1:0]   head;

  wb_load_align #(.XLEN(XLEN)) u_load_align (
    .funct3 (in_funct3),
    .off    (in_alu_result[1:0]),
    .rdata  (in_mem_rdata),
    .data   (load_data)
  );

  always_comb begin
    case (in_wb_sel)
      WB_SEL_MEM: push_data = load_data;
      WB_SEL_PC4: push_data = in_pc_plus4;
      WB_SEL_IMM: push_data = in_imm;
      default:    push_data = in_alu_result;
    endcase
  end

  // Writes to x0 keep their slot so ordering stays intact, but never commit.
  assign push_we  = in_reg_write && (in_rd_addr != 5'd0);
  assign in_ready = (occupancy != FULL);
  assign push     = in_valid && in_ready;
  assign pop      = start && (occupancy != '0);
  assign head     = entries[rd_ptr];

  // Queue storage: validity is tracked by pointers/occupancy, not per slot.
  always_ff @(posedge clk) begin
    if (push) entries[wr_ptr] <= {push_we, in_rd_addr, push_data};
  end

  // Commit stage: pointers, occupancy and the register-file write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occupancy    <= '0;
      rf_reg_write <= 1'b0;
      rf_rd_addr   <= '0;
      rf_rd_data   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr       <= rd_ptr + 1'b1;
        rf_reg_write <= head[WE_BIT];
        rf_rd_addr   <= head[RD_MSB -: 5];
        rf_rd_data   <= head[XLEN-1:0];
      end else begin
        rf_reg_write <= 1'b0;
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  logic          hit1;
  logic          hit2;
  logic [AW-1:0] rel;
  logic          live;

  // A slot is live when its distance from the read pointer is below occupancy.
  always_comb begin
    hit1 = rf_reg_write && (rf_rd_addr == rs1_query);
    hit2 = rf_reg_write && (rf_rd_addr == rs2_query);
    rel  = '0;
    live = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rel  = AW'(i) - rd_ptr;
      live = ({1'b0, rel} < occupancy) && entries[i][WE_BIT];
      if (live && (entries[i][RD_MSB -: 5] == rs1_query)) hit1 = 1'b1;
      if (live && (entries[i][RD_MSB -: 5] == rs2_query)) hit2 = 1'b1;
    end
    hazard_rs1 = (rs1_query != 5'd0) && hit1;
    hazard_rs2 = (rs2_query != 5'd0) && hit2;
  end

endmodule

// File: tb/tb_wb_commit_buffer.sv
// Directed bench for wb_commit_buffer: reset, load formatting, source mux,
// x0 handling, stall/full, streaming wrap and hazard reporting.
module tb_wb_commit_buffer;
  import rv32_wb_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int AW    = 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            in_valid;
  logic            in_ready;
  logic            in_reg_write;
  logic [4:0]      in_rd_addr;
  logic [1:0]      in_wb_sel;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_alu_result;
  logic [XLEN-1:0] in_mem_rdata;
  logic [XLEN-1:0] in_pc_plus4;
  logic [XLEN-1:0] in_imm;
  logic            rf_reg_write;
  logic [4:0]      rf_rd_addr;
  logic [XLEN-1:0] rf_rd_data;
  logic [4:0]      rs1_query;
  logic [4:0]      rs2_query;
  logic            hazard_rs1;
  logic            hazard_rs2;
  logic [AW:0]     occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  wb_commit_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_reg_write  (in_reg_write),
    .in_rd_addr    (in_rd_addr),
    .in_wb_sel     (in_wb_sel),
    .in_funct3     (in_funct3),
    .in_alu_result (in_alu_result),
    .in_mem_rdata  (in_mem_rdata),
    .in_pc_plus4   (in_pc_plus4),
    .in_imm        (in_imm),
    .rf_reg_write  (rf_reg_write),
    .rf_rd_addr    (rf_rd_addr),
    .rf_rd_data    (rf_rd_data),
    .rs1_query     (rs1_query),
    .rs2_query     (rs2_query),
    .hazard_rs1    (hazard_rs1),
    .hazard_rs2    (hazard_rs2),
    .occupancy     (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [31:0] pc4, input logic [31:0] imm,
                       input logic rw, input logic [4:0] rd);
    in_wb_sel     = sel;
    in_funct3     = f3;
    in_alu_result = alu;
    in_mem_rdata  = rdata;
    in_pc_plus4   = pc4;
    in_imm        = imm;
    in_reg_write  = rw;
    in_rd_addr    = rd;
    in_valid      = 1'b1;
  endtask

  // Push one load with start=1, then sample the rf port one edge later.
  task automatic load_case(input string tag, input logic [2:0] f3, input logic [1:0] off,
                           input logic [31:0] exp);
    drive(WB_SEL_MEM, f3, 32'h0000_1000 + 32'(off), 32'h8899_AABB, 32'h0, 32'h0, 1'b1, 5'd10);
    tick();
    in_valid = 1'b0;
    tick();
    check(tag, rf_rd_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    rs1_query = 5'd0; rs2_query = 5'd0;
    drive(WB_SEL_ALU, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_we", 32'(rf_reg_write), 32'd0);
    check("rst_addr", 32'(rf_rd_addr), 32'd0);
    check("rst_data", rf_rd_data, 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);

    // Reset with one entry queued and drain frozen.
    rs1_query = 5'd3;
    drive(WB_SEL_ALU, 3'd0, 32'h55, 32'h0, 32'h0, 32'h0, 1'b1, 5'd3);
    tick();
    in_valid = 1'b0;
    check("pre_rst_occ", 32'(occupancy), 32'd1);
    check("pre_rst_haz", 32'(hazard_rs1), 32'd1);
    reset = 1'b1;
    #2 reset = 1'b0;
    tick();
    check("midrst_occ", 32'(occupancy), 32'd0);
    check("midrst_we", 32'(rf_reg_write), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_haz", 32'(hazard_rs1), 32'd0);
    rs1_query = 5'd0;

    start = 1'b1;
    load_case("lb_off1",  F3_LB,  2'd1, 32'hFFFF_FFAA);
    load_case("lbu_off1", F3_LBU, 2'd1, 32'h0000_00AA);
    load_case("lh_off2",  F3_LH,  2'd2, 32'hFFFF_8899);
    load_case("lhu_off2", F3_LHU, 2'd2, 32'h0000_8899);
    load_case("lw",       F3_LW,  2'd0, 32'h8899_AABB);
    load_case("lb_off0",  F3_LB,  2'd0, 32'hFFFF_FFBB);
    load_case("lbu_off3", F3_LBU, 2'd3, 32'h0000_0088);
    load_case("lh_off0",  F3_LH,  2'd0, 32'hFFFF_AABB);
    load_case("lhu_off0", F3_LHU, 2'd0, 32'h0000_AABB);
    load_case("f3_other", 3'b011, 2'd1, 32'h8899_AABB);

    // Source mux.
    drive(WB_SEL_PC4, 3'd0, 32'hDEAD_0000, 32'h1111_1111, 32'h104, 32'h1234_5000, 1'b1, 5'd5);
    tick();
    in_valid = 1'b0;
    tick();
    check("pc4_we", 32'(rf_reg_write), 32'd1);
    check("pc4_addr", 32'(rf_rd_addr), 32'd5);
    check("pc4_data", rf_rd_data, 32'h104);
    drive(WB_SEL_IMM, 3'd0, 32'hDEAD_0000, 32'h1111_1111, 32'h104, 32'h1234_5000, 1'b1, 5'd6);
    tick();
    in_valid = 1'b0;
    tick();
    check("imm_addr", 32'(rf_rd_addr), 32'd6);
    check("imm_data", rf_rd_data, 32'h1234_5000);
    drive(WB_SEL_ALU, 3'd0, 32'hCAFE_0001, 32'h1111_1111, 32'h104, 32'h1234_5000, 1'b1, 5'd9);
    tick();
    in_valid = 1'b0;
    tick();
    check("alu_addr", 32'(rf_rd_addr), 32'd9);
    check("alu_data", rf_rd_data, 32'hCAFE_0001);

    // rd = x0 consumes a slot but never writes.
    drive(WB_SEL_PC4, 3'd0, 32'h0, 32'h0, 32'h200, 32'h0, 1'b1, 5'd0);
    tick();
    in_valid = 1'b0;
    check("x0_occ", 32'(occupancy), 32'd1);
    tick();
    check("x0_we", 32'(rf_reg_write), 32'd0);
    check("x0_drained", 32'(occupancy), 32'd0);

    // Stall until full, then release.
    start = 1'b0;
    drive(WB_SEL_ALU, 3'd0, 32'hA, 32'h0, 32'h0, 32'h0, 1'b1, 5'd11);
    tick();
    drive(WB_SEL_ALU, 3'd0, 32'hB, 32'h0, 32'h0, 32'h0, 1'b1, 5'd12);
    tick();
    check("full_occ", 32'(occupancy), 32'd2);
    check("full_ready", 32'(in_ready), 32'd0);
    drive(WB_SEL_ALU, 3'd0, 32'hC, 32'h0, 32'h0, 32'h0, 1'b1, 5'd13);
    tick();
    check("held_occ", 32'(occupancy), 32'd2);
    check("held_we", 32'(rf_reg_write), 32'd0);
    start = 1'b1;
    tick();
    check("rel_a_we", 32'(rf_reg_write), 32'd1);
    check("rel_a_addr", 32'(rf_rd_addr), 32'd11);
    check("rel_a_data", rf_rd_data, 32'hA);
    check("rel_a_occ", 32'(occupancy), 32'd1);
    tick();
    in_valid = 1'b0;
    check("rel_b_addr", 32'(rf_rd_addr), 32'd12);
    check("rel_b_data", rf_rd_data, 32'hB);
    check("rel_b_occ", 32'(occupancy), 32'd1);
    tick();
    check("rel_c_addr", 32'(rf_rd_addr), 32'd13);
    check("rel_c_data", rf_rd_data, 32'hC);
    check("rel_c_occ", 32'(occupancy), 32'd0);
    tick();
    check("rel_idle_we", 32'(rf_reg_write), 32'd0);

    // Back-to-back stream wrapping the pointers several times.
    for (int k = 0; k < 8; k++) begin
      drive(WB_SEL_ALU, 3'd0, 32'h100 + 32'(k), 32'h0, 32'h0, 32'h0, 1'b1, 5'(k + 1));
      tick();
      if (k > 0) begin
        check("strm_we", 32'(rf_reg_write), 32'd1);
        check("strm_addr", 32'(rf_rd_addr), 32'(k));
        check("strm_data", rf_rd_data, 32'h100 + 32'(k - 1));
      end
    end
    in_valid = 1'b0;
    tick();
    check("strm_last_addr", 32'(rf_rd_addr), 32'd8);
    check("strm_last_data", rf_rd_data, 32'h107);
    check("strm_occ", 32'(occupancy), 32'd0);
    tick();
    check("strm_idle_we", 32'(rf_reg_write), 32'd0);

    // Hazards.
    start = 1'b0;
    drive(WB_SEL_ALU, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd7);
    tick();
    in_valid = 1'b0;
    rs1_query = 5'd7;
    #1;
    check("haz_nowe", 32'(hazard_rs1), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    drive(WB_SEL_ALU, 3'd0, 32'h77, 32'h0, 32'h0, 32'h0, 1'b1, 5'd7);
    tick();
    in_valid = 1'b0;
    rs2_query = 5'd7;
    #1;
    check("haz_rs1_q7", 32'(hazard_rs1), 32'd1);
    check("haz_rs2_q7", 32'(hazard_rs2), 32'd1);
    rs1_query = 5'd8;
    #1;
    check("haz_q8", 32'(hazard_rs1), 32'd0);
    rs1_query = 5'd0;
    #1;
    check("haz_q0", 32'(hazard_rs1), 32'd0);
    rs1_query = 5'd7;
    start = 1'b1;
    tick();
    check("haz_rf_we", 32'(rf_reg_write), 32'd1);
    check("haz_rf_stage", 32'(hazard_rs1), 32'd1);
    tick();
    check("haz_clear_we", 32'(rf_reg_write), 32'd0);
    check("haz_clear", 32'(hazard_rs1), 32'd0);
    check("haz_clear_rs2", 32'(hazard_rs2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
